// File: rtl/proc_run_monitor_pkg.sv
// rtl/proc_run_monitor_pkg.sv - state encoding and trace entry sizing shared by proc_run_monitor
package proc_run_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } run_state_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_CNT_W  = 16;

   // One trace entry is {core_out, cycle_cnt}.
   function automatic int trace_entry_w(input int data_w, input int cnt_w);
      return data_w + cnt_w;
   endfunction

endpackage

// File: rtl/proc_mon_trace_fifo.sv
// rtl/proc_mon_trace_fifo.sv - first-word-fall-through trace FIFO that reports pushes dropped on full
module proc_mon_trace_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_drop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_wr_en;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = !w_empty && i_ready;
   // A push into a full FIFO survives only if the head leaves in the same cycle.
   assign w_wr_en = i_push && (!w_full || w_pop);
   assign o_drop  = i_push && w_full && !w_pop;
   assign o_valid = !w_empty;
   assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
      end
   end

endmodule

// File: rtl/proc_run_monitor.sv
// rtl/proc_run_monitor.sv - reset sequencer, run-cycle counter and out-bus tracer for Processor_main
// Optional stall termination is built when PROC_RUN_MONITOR_STALL_DETECT_EN is defined.
module proc_run_monitor
   import proc_run_monitor_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int RST_CYCLES   = 2,
   parameter int MAX_CYCLES   = 1024,
   parameter int TRACE_DEPTH  = 16
`ifdef PROC_RUN_MONITOR_STALL_DETECT_EN
   ,parameter int STALL_CYCLES = 64
`endif
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   output logic              o_core_reset,
   input  logic [DATA_W-1:0] i_core_out,
   input  logic              i_expect_en,
   input  logic [DATA_W-1:0] i_expect_val,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic              o_timeout,
   output logic [CNT_W-1:0]  o_cycle_cnt,
   output logic              o_trace_valid,
   input  logic              i_trace_ready,
   output logic [DATA_W-1:0] o_trace_data,
   output logic [CNT_W-1:0]  o_trace_time,
   output logic              o_trace_overflow
`ifdef PROC_RUN_MONITOR_STALL_DETECT_EN
   ,output logic             o_stall
`endif
);

   localparam int               LP_ENTRY_W   = trace_entry_w(DATA_W, CNT_W);
   localparam int               LP_HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [LP_HOLD_W-1:0] LP_HOLD_INIT = LP_HOLD_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

   run_state_t              r_state;
   run_state_t              w_state_next;
   logic [LP_HOLD_W-1:0]    r_hold_cnt;
   logic [CNT_W-1:0]        r_cycle_cnt;
   logic [DATA_W-1:0]       r_prev;
   logic                    r_pass;
   logic                    r_timeout;
   logic                    r_overflow;

   logic                    w_start_ok;
   logic                    w_match;
   logic                    w_last;
   logic                    w_push;
   logic                    w_drop;
   logic                    w_stall_hit;
   logic                    w_end_pass;
   logic                    w_end_timeout;
   logic                    w_end_stall;
   logic                    w_core_reset;
   logic                    w_busy;
   logic                    w_done;
   logic [LP_ENTRY_W-1:0]   w_trace_entry;

   assign w_start_ok = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_match    = i_expect_en && (i_core_out == i_expect_val);
   assign w_last     = (r_cycle_cnt == LP_LAST_CYCLE);
   // cycle_cnt is zero only on the first RUN cycle, which is always captured.
   assign w_push     = (r_state == ST_RUN) &&
                       ((r_cycle_cnt == '0) || (i_core_out != r_prev));

`ifdef PROC_RUN_MONITOR_STALL_DETECT_EN
   localparam logic [CNT_W-1:0] LP_STALL_LAST = CNT_W'(STALL_CYCLES - 1);

   logic [CNT_W-1:0] r_stall_cnt;
   logic             r_stall;

   assign w_stall_hit = !w_push && (r_stall_cnt == LP_STALL_LAST);
   assign o_stall     = r_stall;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_stall_cnt <= '0;
         r_stall     <= 1'b0;
      end else if (w_start_ok) begin
         r_stall_cnt <= '0;
         r_stall     <= 1'b0;
      end else if (r_state == ST_RUN) begin
         r_stall_cnt <= w_push ? '0 : r_stall_cnt + 1'b1;
         if (w_end_stall) begin
            r_stall <= 1'b1;
         end
      end
   end
`else
   assign w_stall_hit = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_core_reset  = 1'b1;
      w_busy        = 1'b0;
      w_done        = 1'b0;
      w_end_pass    = 1'b0;
      w_end_timeout = 1'b0;
      w_end_stall   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            w_busy = 1'b1;
            if (r_hold_cnt == '0) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_busy       = 1'b1;
            w_core_reset = 1'b0;
            // Termination priority: match, then cycle limit, then stall.
            if (w_match) begin
               w_end_pass   = 1'b1;
               w_state_next = ST_DONE;
            end else if (w_last) begin
               w_end_timeout = 1'b1;
               w_state_next  = ST_DONE;
            end else if (w_stall_hit) begin
               w_end_stall  = 1'b1;
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_done = 1'b1;
            if (i_start) begin
               w_state_next = ST_HOLD;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_hold_cnt  <= '0;
         r_cycle_cnt <= '0;
         r_prev      <= '0;
         r_pass      <= 1'b0;
         r_timeout   <= 1'b0;
         r_overflow  <= 1'b0;
      end else if (w_start_ok) begin
         r_hold_cnt  <= LP_HOLD_INIT;
         r_cycle_cnt <= '0;
         r_pass      <= 1'b0;
         r_timeout   <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if ((r_state == ST_HOLD) && (r_hold_cnt != '0)) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
         end
         if (r_state == ST_RUN) begin
            r_prev <= i_core_out;
            // The counter freezes on the terminating cycle so it reports where the run ended.
            if (w_state_next == ST_RUN) begin
               r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            if (w_end_pass) begin
               r_pass <= 1'b1;
            end
            if (w_end_timeout) begin
               r_timeout <= 1'b1;
            end
         end
      end
   end

   assign w_trace_entry = {i_core_out, r_cycle_cnt};

   logic [LP_ENTRY_W-1:0] w_trace_head;

   proc_mon_trace_fifo #(
      .WIDTH (LP_ENTRY_W),
      .DEPTH (TRACE_DEPTH)
   ) u_trace_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_flush (w_start_ok),
      .i_push  (w_push),
      .i_wdata (w_trace_entry),
      .i_ready (i_trace_ready),
      .o_valid (o_trace_valid),
      .o_rdata (w_trace_head),
      .o_drop  (w_drop)
   );

   assign o_trace_data     = w_trace_head[LP_ENTRY_W-1:CNT_W];
   assign o_trace_time     = w_trace_head[CNT_W-1:0];
   assign o_core_reset     = w_core_reset;
   assign o_busy           = w_busy;
   assign o_done           = w_done;
   assign o_pass           = r_pass;
   assign o_timeout        = r_timeout;
   assign o_cycle_cnt      = r_cycle_cnt;
   assign o_trace_overflow = r_overflow;

endmodule

// File: tb/tb_proc_run_monitor.sv
// tb/tb_proc_run_monitor.sv - scoreboard bench for proc_run_monitor (RST_CYCLES=2, MAX_CYCLES=32, TRACE_DEPTH=4)
module tb_proc_run_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        core_reset;
   logic [15:0] core_out;
   logic        expect_en;
   logic [15:0] expect_val;
   logic        busy;
   logic        done;
   logic        pass;
   logic        timeout;
   logic [15:0] cycle_cnt;
   logic        trace_valid;
   logic        trace_ready;
   logic [15:0] trace_data;
   logic [15:0] trace_time;
   logic        trace_overflow;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_e;
   logic [15:0] cyc;

   always #5 clk = ~clk;

   proc_run_monitor #(
      .DATA_W      (16),
      .CNT_W       (16),
      .RST_CYCLES  (2),
      .MAX_CYCLES  (32),
      .TRACE_DEPTH (4)
   ) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_start          (start),
      .o_core_reset     (core_reset),
      .i_core_out       (core_out),
      .i_expect_en      (expect_en),
      .i_expect_val     (expect_val),
      .o_busy           (busy),
      .o_done           (done),
      .o_pass           (pass),
      .o_timeout        (timeout),
      .o_cycle_cnt      (cycle_cnt),
      .o_trace_valid    (trace_valid),
      .i_trace_ready    (trace_ready),
      .o_trace_data     (trace_data),
      .o_trace_time     (trace_time),
      .o_trace_overflow (trace_overflow)
   );

   // Trace monitor: every accepted head is compared with the oldest expected entry.
   always @(negedge clk) begin
      if (trace_valid && trace_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL trace_unexpected got data=%h time=%0d expected none", trace_data, trace_time);
         end else begin
            exp_e = exp_q.pop_front();
            if ({trace_data, trace_time} !== exp_e) begin
               n_bad++;
               $display("FAIL trace_entry got data=%h time=%0d expected data=%h time=%0d",
                        trace_data, trace_time, exp_e[31:16], exp_e[15:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [15:0] val, input bit cap);
      core_out = val;
      if (cap) exp_q.push_back({val, cyc});
      cyc = cyc + 16'd1;
      tick();
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("hold_busy", busy, 1);
      check("hold_core_reset_1", core_reset, 1);
      check("hold_pass_clr", pass, 0);
      check("hold_timeout_clr", timeout, 0);
      check("hold_overflow_clr", trace_overflow, 0);
      check("hold_cycle_clr", cycle_cnt, 0);
      tick();
      check("hold_core_reset_2", core_reset, 1);
      tick();
      check("run_core_reset", core_reset, 0);
      check("run_first_cycle", cycle_cnt, 0);
      cyc = 16'd0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      core_out = 16'h0;
      expect_en = 1'b0;
      expect_val = 16'h0;
      trace_ready = 1'b0;
      cyc = 16'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_core_reset", core_reset, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_timeout", timeout, 0);
      check("rst_overflow", trace_overflow, 0);
      check("rst_cycle", cycle_cnt, 0);
      check("rst_trace_valid", trace_valid, 0);
      reset = 1'b0;
      tick();

      // Reset hold, then change capture without repeats.
      start_run();
      drive(16'h0000, 1);
      drive(16'h0005, 1);
      drive(16'h0005, 0);
      drive(16'h000A, 1);
      check("t2_trace_valid", trace_valid, 1);

      // Match on 0x0012 at run cycle 7.
      trace_ready = 1'b1;
      expect_en = 1'b1;
      expect_val = 16'h0012;
      drive(16'h000A, 0);
      drive(16'h000A, 0);
      drive(16'h000C, 1);
      drive(16'h0012, 1);
      check("t3_done", done, 1);
      check("t3_pass", pass, 1);
      check("t3_timeout", timeout, 0);
      check("t3_cycle", cycle_cnt, 7);
      check("t3_core_reset", core_reset, 1);
      check("t3_busy", busy, 0);
      expect_en = 1'b0;
      wait_drain();

      // Cycle-limit timeout.
      core_out = 16'h0077;
      start_run();
      drive(16'h0077, 1);
      for (int i = 0; i < 60 && !done; i++) drive(16'h0077, 0);
      check("t4_done", done, 1);
      check("t4_timeout", timeout, 1);
      check("t4_pass", pass, 0);
      check("t4_cycle", cycle_cnt, 31);
      wait_drain();

      // Full FIFO: push with pop accepted, push without pop dropped.
      trace_ready = 1'b0;
      core_out = 16'h0001;
      start_run();
      drive(16'h0001, 1);
      drive(16'h0002, 1);
      drive(16'h0003, 1);
      drive(16'h0004, 1);
      check("t5_full_valid", trace_valid, 1);
      check("t5_no_ovf_yet", trace_overflow, 0);
      trace_ready = 1'b1;
      drive(16'h0005, 1);
      trace_ready = 1'b0;
      check("t5_pop_push_no_ovf", trace_overflow, 0);
      drive(16'h0006, 0);
      drive(16'h0007, 0);
      check("t5_overflow", trace_overflow, 1);
      trace_ready = 1'b1;
      drive(16'h0007, 0);
      drive(16'h0007, 0);
      trace_ready = 1'b0;
      check("t5_left_valid", trace_valid, 1);
      check("t5_still_busy", busy, 1);

      // Asynchronous reset mid-run with entries still queued.
      reset = 1'b1;
      #1;
      check("t6_core_reset", core_reset, 1);
      check("t6_busy", busy, 0);
      check("t6_done", done, 0);
      check("t6_trace_valid", trace_valid, 0);
      check("t6_overflow", trace_overflow, 0);
      check("t6_cycle", cycle_cnt, 0);
      check("t6_pass", pass, 0);
      exp_q.delete();
      tick();
      reset = 1'b0;
      tick();

      // Match and timeout on the same cycle: match wins.
      trace_ready = 1'b1;
      expect_en = 1'b1;
      expect_val = 16'h0055;
      core_out = 16'h0011;
      start_run();
      drive(16'h0011, 1);
      for (int i = 1; i < 31; i++) drive(16'h0011, 0);
      check("t7_cycle_before", cycle_cnt, 31);
      drive(16'h0055, 1);
      check("t7_done", done, 1);
      check("t7_pass", pass, 1);
      check("t7_timeout", timeout, 0);
      check("t7_cycle", cycle_cnt, 31);
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
